// File: rtl/serial_block_deinterleaver.sv
// rtl/serial_block_deinterleaver.sv - bit-serial 4x7 block deinterleaver, column-major in, row-major parallel out
`timescale 1ns/1ps
module serial_block_deinterleaver #(
  parameter int ROWS = 4,
  parameter int COLS = 7,
  localparam int N = ROWS * COLS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_bit,
  input  logic         in_sof,
  output logic         out_valid,
  output logic [N-1:0] data_out,
  output logic         frame_err
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  data_q, data_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [KW-1:0] wr_idx;

  // Row/column counters replace a divide of k by ROWS.
  assign wr_idx = KW'(int'(r_q) * COLS + int'(c_q));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    r_d         = r_q;
    c_d         = c_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // A SOF mid-frame (including on the final bit) aborts and restarts.
        frame_err_d = (state_q == RECV);
        shadow_d[0] = in_bit;
        k_d         = KW'(1);
        r_d         = RW'(1);
        c_d         = '0;
        state_d     = RECV;
      end else if (state_q == RECV) begin
        shadow_d[wr_idx] = in_bit;
        if (k_q == KW'(N - 1)) begin
          data_d      = shadow_d;
          out_valid_d = 1'b1;
          state_d     = IDLE;
          k_d         = '0;
          r_d         = '0;
          c_d         = '0;
        end else begin
          k_d = k_q + KW'(1);
          if (r_q == RW'(ROWS - 1)) begin
            r_d = '0;
            c_d = c_q + CW'(1);
          end else begin
            r_d = r_q + RW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      r_q         <= r_d;
      c_q         <= c_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign data_out  = data_q;

endmodule

// File: doc/serial_block_deinterleaver.md
# serial_block_deinterleaver

Bit-serial receive-side block deinterleaver for the 28-bit interleaved link. It accepts the channel bit stream one bit per valid cycle in interleaved (column-major) order and reassembles each 28-bit frame in original (row-major) order. It presents the frame as a parallel word with a one-cycle valid pulse. It sits after the channel/demodulator stage and feeds the parallel decoding path, providing the serial counterpart of the parallel interleaver.

## Interface
- ROWS, 4, rows of the block interleaver matrix
- COLS, 7, columns of the block interleaver matrix
- N, ROWS*COLS (28), frame length in bits; derived, not overridden
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_bit is valid this cycle
- in_bit  input  1  serial channel bit
- in_sof  input  1  start of frame; qualified by in_valid, marks serial index k=0
- out_valid  output  1  one-cycle pulse: data_out holds a newly completed frame
- data_out  output  N  deinterleaved frame; bit i = original bit i
- frame_err  output  1  one-cycle pulse: frame aborted by early in_sof

## Operation
- Permutation: serial index k = c*ROWS + r (r in 0..ROWS-1, c in 0..COLS-1) maps to output index i = r*COLS + c.
- Bit counter k, width ceil(log2 N), counts accepted bits 0..N-1.
- Shadow register, N bits, collects the frame being received.
- Row/column are tracked as separate counters r (0..ROWS-1) and c (0..COLS-1). Each accepted bit increments r; when r wraps, c increments. No divider is used.
- State machine:
  - IDLE: in_valid & in_sof accepts bit k=0 and moves to RECV. Other valid bits are discarded.
  - RECV: each in_valid cycle writes in_bit to shadow[r*COLS+c] and advances the counters.
  - When k==N-1 is accepted, the next data_out = shadow with that last bit merged, out_valid pulses, and the state goes to IDLE.
- Back-to-back frames: in_sof on the cycle after the last bit is accepted normally. No dead cycle is required.
- in_sof asserted in RECV with k!=0:
  - The partial frame is discarded and frame_err pulses.
  - The current bit is taken as k=0 of a new frame and the state stays in RECV.
- in_sof with k==N-1 while in RECV: treated as an early SOF. The frame is aborted, frame_err pulses, and out_valid does not pulse.
- in_valid=0: no state change; gaps of any length are allowed mid-frame.
- in_sof and in_bit are ignored when in_valid=0.
- data_out holds its value between completions and changes only on a completion cycle.
- Shadow register is not cleared between frames; every position is overwritten within a complete frame.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, k=r=c=0, shadow=0, data_out=0, out_valid=0, frame_err=0.
- Release of rst is synchronous to clk. The first in_valid can be accepted on the first rising edge with rst=1.
- Latency: last bit accepted at edge t, so out_valid=1 and data_out is valid in the cycle after edge t. Both are registered.
- out_valid and frame_err are each high for exactly one cycle per event. They are never high in the same cycle.
- Throughput: one bit per clk. Minimum frame period is N cycles.
- Reset asserted mid-frame: the partial frame is lost and outputs return to reset values immediately.

## Test plan
- Reset check: hold rst=0 over several edges -> data_out=0, out_valid=0, frame_err=0. Release, then idle 5 cycles -> no pulses.
- Single-bit map: a 28-bit frame, continuous valid, with only the bit at k=1 set -> data_out=28'h0000080 (i=7), one out_valid pulse the cycle after k=27. Repeat with k=4 -> 28'h0000002, and with k=27 -> 28'h8000000.
- Round trip: stream the column-major serialization of 28'b0011111000011110110111100101 -> data_out=28'b0011111000011110110111100101. Then send a second frame of all ones back-to-back -> data_out=28'hFFFFFFF exactly N cycles after the first pulse.
- Gapped input: same frame with in_valid deasserted for 3 cycles after k=10 and k=20 -> identical data_out, with out_valid delayed by 6 cycles.
- Early SOF: in_sof at k=15 -> frame_err pulse, no out_valid. The new 28-bit frame then completes with correct data, and data_out keeps its prior value until then.
- Async reset mid-frame: rst=0 at k=12 between edges -> outputs go to 0 without a clock edge. A fresh frame after release decodes correctly.
